pipe_mem_wb: RTL and testbench
==============================

PIPE_MEM_WB -- requirements
Module: pipe_mem_wb

Interface
REQ-001 Parameter: CNT_WIDTH, default 64, width of the retired-instruction counter.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: StallW  in  1  hold all WB-stage registers.
REQ-006 Port: FlushW  in  1  load a bubble into WB.
REQ-007 Port: ValidM  in  1  MEM stage holds a real instruction.
REQ-008 Port: RegWriteM  in  1  instruction writes rd.
REQ-009 Port: ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4.
REQ-010 Port: RdM  in  5  destination register index.
REQ-011 Port: Funct3M  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 Port: ALUResultM  in  32  ALU result, also the load address.
REQ-013 Port: ReadDataM  in  32  raw aligned word from data memory.
REQ-014 Port: PCPlus4M  in  32  PC+4 of the MEM instruction.
REQ-015 Ports, registered outputs: ValidW 1, RegWriteW 1, ResultSrcW 2, RdW 5, ALUResultW 32, ReadDataW 32 (extracted and extended), PCPlus4W 32.
REQ-016 Port: LoadMisalignW  out  1  registered misaligned-load flag.
REQ-017 Port: InstRetW  out  CNT_WIDTH  count of retired instructions.

Function
REQ-018 Update priority per edge: rst > FlushW > StallW > normal capture.
REQ-019 Normal capture: every output takes its MEM-side value, or the value derived from it, one cycle later; latency is exactly 1 cycle.
REQ-020 StallW=1, FlushW=0: every WB register, including LoadMisalignW, holds its value.
REQ-021 FlushW=1: ValidW=0, RegWriteW=0, LoadMisalignW=0, ResultSrcW=00, RdW=0, data outputs=0; FlushW wins over a simultaneous StallW.
REQ-022 Load extraction uses offset = ALUResultM[1:0].
- LB/LBU: byte ReadDataM[8*offset+7 : 8*offset], sign-extended (LB) or zero-extended (LBU).
- LH/LHU: half selected by offset[1], sign-extended (LH) or zero-extended (LHU).
- LW: the full word.
REQ-023 Funct3M values 011, 110 and 111 pass ReadDataM unmodified, with no misalign flag.
REQ-024 Misaligned load is ResultSrcM=01 and ValidM=1 and either (LH/LHU with offset[0]=1) or (LW with offset!=00).
REQ-025 On a misaligned load: LoadMisalignW=1, RegWriteW=0, ReadDataW=0.
REQ-026 For ResultSrcM other than 01, ReadDataW still takes the extracted value; no misalign check is made.
REQ-027 RegWriteW = RegWriteM & ValidM & ~misalign.
REQ-028 RdM=0 passes through unchanged; x0 suppression belongs to the register file.
REQ-029 InstRetW increments by 1 on an edge where ValidW=1, StallW=0 and rst=0; this counts instructions leaving WB, and FlushW does not block the increment.
REQ-030 InstRetW wraps from all-ones to 0 with no flag.
REQ-031 Logic is purely edge-registered with no combinational path from inputs to outputs.

Reset
REQ-032 With rst=1 at an edge, all outputs are 0, including InstRetW, regardless of StallW and FlushW.
REQ-033 A reset in mid-stall or mid-flush discards held state; capture resumes on the first edge with rst=0.

Verification
REQ-034 LB and LBU: ReadDataM=0x80F1_7F22, ALUResultM=0x...03, ResultSrcM=01.
- LB gives ReadDataW=0xFFFF_FF80.
- LBU gives ReadDataW=0x0000_0080.
- Both have LoadMisalignW=0 and RegWriteW=1, one cycle later.
REQ-035 LH on the same word with offset=10 gives ReadDataW=0xFFFF_80F1. LW with offset=01 gives LoadMisalignW=1, RegWriteW=0 and ReadDataW=0.
REQ-036 Stall, then flush:
- Capture instruction A; hold StallW=1 for 3 cycles: outputs stay at A and InstRetW does not change.
- Then assert FlushW=1 with StallW=1: the next edge gives ValidW=0 and RegWriteW=0.
REQ-037 Stream 5 valid instructions with no stall: InstRetW reads 5 one edge after the fifth is in WB. Preload InstRetW to all-ones via a directed force and retire one instruction: InstRetW reads 0.
REQ-038 With ValidM=1, ResultSrcM=10 and PCPlus4M=0x0000_0104, the next edge gives PCPlus4W=0x104 and ResultSrcW=10. Asserting rst on the following edge zeroes every output.

Source files
------------

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register: extracts and extends load data, flags misaligned
// loads, and counts instructions as they leave the writeback stage.
module pipe_mem_wb #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallW,
  input  logic                 FlushW,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [4:0]           RdM,
  input  logic [2:0]           Funct3M,
  input  logic [31:0]          ALUResultM,
  input  logic [31:0]          ReadDataM,
  input  logic [31:0]          PCPlus4M,
  output logic                 ValidW,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RdW,
  output logic [31:0]          ALUResultW,
  output logic [31:0]          ReadDataW,
  output logic [31:0]          PCPlus4W,
  output logic                 LoadMisalignW,
  output logic [CNT_WIDTH-1:0] InstRetW
);

  logic [1:0]  offset_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_data_s;
  logic        misalign_s;

  // Select the addressed byte and halfword out of the aligned memory word.
  always_comb begin
    offset_s = ALUResultM[1:0];
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    case (offset_s)
      2'b00:   byte_s = ReadDataM[7:0];
      2'b01:   byte_s = ReadDataM[15:8];
      2'b10:   byte_s = ReadDataM[23:16];
      2'b11:   byte_s = ReadDataM[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset_s[1]) begin
      half_s = ReadDataM[31:16];
    end else begin
      half_s = ReadDataM[15:0];
    end
  end

  // Extend the selected field according to the load type; unknown types pass the word through.
  always_comb begin
    load_data_s = ReadDataM;
    case (Funct3M)
      3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_data_s = {{16{half_s[15]}}, half_s};
      3'b010:  load_data_s = ReadDataM;
      3'b100:  load_data_s = {24'h000000, byte_s};
      3'b101:  load_data_s = {16'h0000, half_s};
      default: load_data_s = ReadDataM;
    endcase
  end

  // Misalignment only matters for real instructions that consume load data.
  always_comb begin
    misalign_s = 1'b0;
    if (ValidM && (ResultSrcM == 2'b01)) begin
      case (Funct3M)
        3'b001:  misalign_s = offset_s[0];
        3'b101:  misalign_s = offset_s[0];
        3'b010:  misalign_s = (offset_s != 2'b00);
        default: misalign_s = 1'b0;
      endcase
    end else begin
      misalign_s = 1'b0;
    end
  end

  // WB stage register: reset, then bubble, then hold, then capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ValidW        <= 1'b0;
      RegWriteW     <= 1'b0;
      ResultSrcW    <= 2'b00;
      RdW           <= 5'd0;
      ALUResultW    <= 32'h0000_0000;
      ReadDataW     <= 32'h0000_0000;
      PCPlus4W      <= 32'h0000_0000;
      LoadMisalignW <= 1'b0;
    end else if (FlushW) begin
      ValidW        <= 1'b0;
      RegWriteW     <= 1'b0;
      ResultSrcW    <= 2'b00;
      RdW           <= 5'd0;
      ALUResultW    <= 32'h0000_0000;
      ReadDataW     <= 32'h0000_0000;
      PCPlus4W      <= 32'h0000_0000;
      LoadMisalignW <= 1'b0;
    end else if (!StallW) begin
      ValidW        <= ValidM;
      RegWriteW     <= RegWriteM & ValidM & ~misalign_s;
      ResultSrcW    <= ResultSrcM;
      RdW           <= RdM;
      ALUResultW    <= ALUResultM;
      ReadDataW     <= misalign_s ? 32'h0000_0000 : load_data_s;
      PCPlus4W      <= PCPlus4M;
      LoadMisalignW <= misalign_s;
    end
  end

  // Retired-instruction counter: counts the instruction leaving WB; a flush does not stop it.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstRetW <= {CNT_WIDTH{1'b0}};
    end else if (ValidW && !StallW) begin
      InstRetW <= InstRetW + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Self-checking bench for pipe_mem_wb: directed cases plus randomized traffic
// compared against a behavioural model of the writeback stage.
module tb_pipe_mem_wb;

  logic        clk = 1'b0;
  logic        rst, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;

  logic        ValidW, RegWriteW, LoadMisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [63:0] InstRetW;

  logic        v3, rw3, lm3;
  logic [1:0]  rs3;
  logic [4:0]  rd3;
  logic [31:0] alu3, rdat3, pc3;
  logic [2:0]  cnt3;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic        e_valid, e_rw, e_mis;
  logic [1:0]  e_rs;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_rdata, e_pc;
  logic [63:0] e_cnt;
  int          e_cnt3;
  logic [63:0] saved_cnt;

  always #5 clk = ~clk;

  pipe_mem_wb dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .LoadMisalignW(LoadMisalignW), .InstRetW(InstRetW)
  );

  // narrow-counter copy so the natural wrap is exercised as well
  pipe_mem_wb #(.CNT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ValidW(v3), .RegWriteW(rw3), .ResultSrcW(rs3), .RdW(rd3),
    .ALUResultW(alu3), .ReadDataW(rdat3), .PCPlus4W(pc3),
    .LoadMisalignW(lm3), .InstRetW(cnt3)
  );

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned off, b, h;
    off = addr % 4;
    b   = (word / (1 << (8 * off))) % 256;
    h   = (word / (1 << (16 * (off / 2)))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic ref_mis(input logic v, input logic [1:0] rs, input logic [2:0] f3,
                                   input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (!(v && rs == 2'd1)) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance the model one edge, clock the DUT, then compare every output
  task automatic cycle();
    logic m;
    m = ref_mis(ValidM, ResultSrcM, Funct3M, ALUResultM);
    if (rst) begin
      {e_valid, e_rw, e_mis, e_rs, e_rd} = '0;
      e_alu = 32'd0; e_rdata = 32'd0; e_pc = 32'd0; e_cnt = 64'd0; e_cnt3 = 0;
    end else begin
      if (e_valid && !StallW) begin
        e_cnt  = e_cnt + 64'd1;
        e_cnt3 = (e_cnt3 + 1) % 8;
      end
      if (FlushW) begin
        {e_valid, e_rw, e_mis, e_rs, e_rd} = '0;
        e_alu = 32'd0; e_rdata = 32'd0; e_pc = 32'd0;
      end else if (!StallW) begin
        e_valid = ValidM;
        e_mis   = m;
        e_rw    = RegWriteM && ValidM && !m;
        e_rs    = ResultSrcM;
        e_rd    = RdM;
        e_alu   = ALUResultM;
        e_rdata = m ? 32'd0 : ref_load(Funct3M, ALUResultM, ReadDataM);
        e_pc    = PCPlus4M;
      end
    end
    @(posedge clk);
    #1;
    chk("ValidW", ValidW, e_valid);
    chk("RegWriteW", RegWriteW, e_rw);
    chk("ResultSrcW", ResultSrcW, e_rs);
    chk("RdW", RdW, e_rd);
    chk("ALUResultW", ALUResultW, e_alu);
    chk("ReadDataW", ReadDataW, e_rdata);
    chk("PCPlus4W", PCPlus4W, e_pc);
    chk("LoadMisalignW", LoadMisalignW, e_mis);
    chk("InstRetW", InstRetW, e_cnt);
    chk("InstRetW_narrow", cnt3, e_cnt3);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc);
    ValidM = v; RegWriteM = rw; ResultSrcM = rs; Funct3M = f3;
    ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc; RdM = 5'd7;
  endtask

  initial begin
    rst = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h0, 32'hDEAD_BEEF, 32'h4);
    e_valid = 1'b0; e_rw = 1'b0; e_mis = 1'b0; e_rs = 2'b00; e_rd = 5'd0;
    e_alu = 32'd0; e_rdata = 32'd0; e_pc = 32'd0; e_cnt = 64'd0; e_cnt3 = 0;

    // reset state
    cycle(); cycle();
    chk("reset_inst_ret", InstRetW, 64'd0);
    chk("reset_valid", ValidW, 64'd0);
    rst = 1'b0;

    // LB / LBU / LH / misaligned LW on the same word
    drive(1'b1, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'h80F1_7F22, 32'h8);
    cycle();
    chk("lb_data", ReadDataW, 64'hFFFF_FF80);
    chk("lb_mis", LoadMisalignW, 64'd0);
    chk("lb_rw", RegWriteW, 64'd1);
    Funct3M = 3'b100;
    cycle();
    chk("lbu_data", ReadDataW, 64'h0000_0080);
    chk("lbu_rw", RegWriteW, 64'd1);
    Funct3M = 3'b001; ALUResultM = 32'h0000_1002;
    cycle();
    chk("lh_data", ReadDataW, 64'hFFFF_80F1);
    Funct3M = 3'b010; ALUResultM = 32'h0000_1001;
    cycle();
    chk("lw_mis_flag", LoadMisalignW, 64'd1);
    chk("lw_mis_rw", RegWriteW, 64'd0);
    chk("lw_mis_data", ReadDataW, 64'd0);

    // stall holds A for three cycles, then flush wins over stall
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h104);
    cycle();
    saved_cnt = e_cnt;
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'b00, 3'($urandom), $urandom, $urandom, $urandom);
      cycle();
      chk("stall_data", ReadDataW, 64'h1234_5678);
      chk("stall_cnt", InstRetW, saved_cnt);
    end
    FlushW = 1'b1;
    cycle();
    chk("flush_valid", ValidW, 64'd0);
    chk("flush_rw", RegWriteW, 64'd0);
    StallW = 1'b0; FlushW = 1'b0;

    // five back-to-back instructions after a reset
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b000, 32'(i), 32'h0, 32'(4 * i));
      cycle();
    end
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("stream5_cnt", InstRetW, 64'd5);

    // counter wrap from all-ones
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h40, 32'h0, 32'h44);
    cycle();
    #1;
    force dut.InstRetW = {64{1'b1}};
    #1;
    release dut.InstRetW;
    e_cnt = {64{1'b1}};
    cycle();
    chk("wrap_cnt", InstRetW, 64'd0);

    // PC+4 pass-through, then reset zeroes everything
    drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0104);
    cycle();
    chk("pc4_data", PCPlus4W, 64'h104);
    chk("pc4_src", ResultSrcW, 64'd2);
    rst = 1'b1;
    cycle();
    chk("rst_pc4", PCPlus4W, 64'd0);
    chk("rst_src", ResultSrcW, 64'd0);
    chk("rst_cnt", InstRetW, 64'd0);
    rst = 1'b0;

    // randomized traffic, including resets landing mid-stall or mid-flush
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      StallW     = ($urandom_range(0, 3) == 0);
      FlushW     = ($urandom_range(0, 7) == 0);
      ValidM     = ($urandom_range(0, 4) != 0);
      RegWriteM  = 1'($urandom);
      ResultSrcM = 2'($urandom);
      RdM        = 5'($urandom);
      Funct3M    = 3'($urandom);
      ALUResultM = $urandom;
      ReadDataM  = $urandom;
      PCPlus4M   = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
